traffic_light_cpu_debug_mem_ctrl: RTL

TRAFFIC_LIGHT_CPU_DEBUG_MEM_CTRL -- requirements
Module: traffic_light_cpu_debug_mem_ctrl

---
 rtl/traffic_light_cpu_debug_mem_ctrl_pkg.sv | 29 ++
 rtl/traffic_light_cpu_debug_ram.sv | 45 ++++
 rtl/traffic_light_cpu_debug_mem_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_light_cpu_debug_mem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_cpu_debug_mem_ctrl_pkg
// Shared definitions for the debug memory controller: controller FSM state
// encoding, default RAM address width and the field positions inside the
// 38-bit JTAG command/data word (jdo).
// -----------------------------------------------------------------------------
package traffic_light_cpu_debug_mem_ctrl_pkg;

    // Default word-address width of the debug RAM (256 x 32 bits).
    localparam int RAM_AW_DEFAULT = 8;

    // jdo layout. The address/read-flag fields overlap the data field because
    // each JTAG command uses only the fields relevant to it.
    localparam int JDO_W        = 38;
    localparam int JDO_ADDR_HI  = 25;
    localparam int JDO_ADDR_LO  = 18;
    localparam int JDO_RD_BIT   = 17;
    localparam int JDO_DATA_HI  = 34;
    localparam int JDO_DATA_LO  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        J_RD0 = 3'd1,
        J_RD1 = 3'd2,
        J_WR  = 3'd3,
        C_RD  = 3'd4
    } state_t;

endpackage

// File: rtl/traffic_light_cpu_debug_ram.sv
// -----------------------------------------------------------------------------
// traffic_light_cpu_debug_ram
// Single-port synchronous 32-bit RAM with per-byte write enables and one
// cycle of read latency (read-before-write on a same-address access).
// Contents are never reset.
//
// Ports:
//   clk    in   clock
//   we     in   write enable (qualified per lane by be)
//   be     in   byte-lane enables, bit n covers wdata[8n+7:8n]
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data for the address of the previous cycle
// -----------------------------------------------------------------------------
module traffic_light_cpu_debug_ram #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    localparam int DEPTH = 1 << AW;

    // One byte-wide memory per lane keeps each lane a plain inferable RAM.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_reg;

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    mem[addr] <= wdata[gi*8 +: 8];
                end
                rd_reg <= mem[addr];
            end

            assign rdata[gi*8 +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/traffic_light_cpu_debug_mem_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_cpu_debug_mem_ctrl
// Arbitrates a debug RAM between the JTAG debug slave and the CPU data port.
// JTAG commands arrive as single-cycle pulses and always beat the CPU; the CPU
// is stalled with waitrequest while the controller is busy.
//
// Ports:
//   clk                     in   clock, rising edge
//   reset_n                 in   asynchronous active-low reset
//   jdo[37:0]               in   JTAG command/data word
//   take_action_ocimem_a    in   pulse: load MonAReg, optional read
//   take_action_ocimem_b    in   pulse: load MonDReg, write it, increment
//   take_no_action_ocimem_a in   pulse: read at MonAReg, increment
//   address                 in   CPU word address
//   read, write             in   CPU strobes
//   writedata[31:0]         in   CPU write data
//   byteenable[3:0]         in   CPU byte lanes
//   debugaccess             in   CPU write qualifier
//   readdata[31:0]          out  CPU read data (zero outside C_RD)
//   waitrequest             out  CPU stall
//   MonDReg[31:0]           out  JTAG data register
//   MonAReg                 out  JTAG word-address register
//   jtag_busy               out  FSM not in IDLE
//   jtag_overrun            out  sticky: a JTAG pulse was dropped
// -----------------------------------------------------------------------------
module traffic_light_cpu_debug_mem_ctrl
    import traffic_light_cpu_debug_mem_ctrl_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [RAM_AW-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    input  logic              debugaccess,
    output logic [31:0]       readdata,
    output logic              waitrequest,
    output logic [31:0]       MonDReg,
    output logic [RAM_AW-1:0] MonAReg,
    output logic              jtag_busy,
    output logic              jtag_overrun
);

    state_t state_reg, state_next;

    logic [31:0]       mon_d_reg;
    logic [RAM_AW-1:0] mon_a_reg;
    logic              auto_inc_reg;
    logic              overrun_reg;

    // RAM port signals
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    // Datapath strobes from the output decode
    logic ld_data_ram;
    logic inc_addr;

    // jdo bits outside every command field
    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[JDO_W-1:JDO_DATA_HI+1], jdo[JDO_DATA_LO-1:0]};

    logic in_idle;
    logic pulse_any;
    logic accept_a;
    logic accept_b;
    logic accept_na;
    logic drop_pulse;
    logic cpu_wr_go;

    assign in_idle   = (state_reg == IDLE);
    assign pulse_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

    // Priority a > b > no_action; only IDLE accepts anything.
    assign accept_a  = in_idle & take_action_ocimem_a;
    assign accept_b  = in_idle & ~take_action_ocimem_a & take_action_ocimem_b;
    assign accept_na = in_idle & ~take_action_ocimem_a & ~take_action_ocimem_b
                       & take_no_action_ocimem_a;

    // A pulse is lost if it arrives while busy, or loses arbitration in IDLE.
    assign drop_pulse = in_idle
        ? ((take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
           | (take_action_ocimem_b & take_no_action_ocimem_a))
        : pulse_any;

    // CPU write completes in IDLE only when no JTAG pulse and no read compete.
    assign cpu_wr_go = in_idle & ~pulse_any & ~read & write;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    state_next = jdo[JDO_RD_BIT] ? J_RD0 : IDLE;
                end else if (take_action_ocimem_b) begin
                    state_next = J_WR;
                end else if (take_no_action_ocimem_a) begin
                    state_next = J_RD0;
                end else if (read) begin
                    state_next = C_RD;
                end
            end
            J_RD0:   state_next = J_RD1;
            J_RD1:   state_next = IDLE;
            J_WR:    state_next = IDLE;
            C_RD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        ram_addr    = mon_a_reg;
        ram_we      = 1'b0;
        ram_be      = 4'hF;
        ram_wdata   = mon_d_reg;
        readdata    = 32'h0;
        ld_data_ram = 1'b0;
        inc_addr    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!pulse_any && read) begin
                    ram_addr = address;
                end else if (cpu_wr_go) begin
                    ram_addr  = address;
                    ram_we    = debugaccess;
                    ram_be    = byteenable;
                    ram_wdata = writedata;
                end
            end
            J_RD1: begin
                ld_data_ram = 1'b1;
                inc_addr    = auto_inc_reg;
            end
            J_WR: begin
                ram_we   = 1'b1;
                inc_addr = 1'b1;
            end
            C_RD: begin
                readdata = ram_rdata;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    // C_RD is the data phase of a CPU read, so it never stalls.
    assign waitrequest = (read | write)
        & ((in_idle & (pulse_any | read)) | (~in_idle & (state_reg != C_RD)));

    assign jtag_busy    = ~in_idle;
    assign jtag_overrun = overrun_reg;
    assign MonDReg      = mon_d_reg;
    assign MonAReg      = mon_a_reg;

    // ----------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_d_reg    <= 32'h0;
            mon_a_reg    <= '0;
            auto_inc_reg <= 1'b0;
            overrun_reg  <= 1'b0;
        end else begin
            if (accept_a) begin
                mon_a_reg    <= RAM_AW'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
                auto_inc_reg <= 1'b0;
            end else if (inc_addr) begin
                mon_a_reg <= mon_a_reg + RAM_AW'(1);
            end

            if (accept_na) begin
                auto_inc_reg <= 1'b1;
            end

            if (accept_b) begin
                mon_d_reg <= jdo[JDO_DATA_HI:JDO_DATA_LO];
            end else if (ld_data_ram) begin
                mon_d_reg <= ram_rdata;
            end

            // A drop in the same cycle as an accepted ocimem_a keeps the flag set.
            if (drop_pulse) begin
                overrun_reg <= 1'b1;
            end else if (accept_a) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    // Write enable is held off while reset is asserted.
    traffic_light_cpu_debug_ram #(
        .AW (RAM_AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we & reset_n),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule
